// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: scans a downstream 4:1 mux by stepping its select lines,
// dwelling DWELL cycles on each channel, and publishing the four sampled
// bits as one frame with a single-cycle valid pulse and a frame counter.
module mux_scan_ctrl #(
   // Cycles spent on each channel before sampling; legal range 1..16.
   parameter int unsigned DWELL = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       continuous,
   input  logic       z,
   output logic       s0,
   output logic       s1,
   output logic [3:0] data,
   output logic       valid,
   output logic       busy,
   output logic [7:0] frames
);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   // Last dwell count of a channel window; the sample is taken on this edge.
   localparam logic [3:0] CNT_LAST = 4'(DWELL - 1);

   state_t     state_q, state_d;
   logic [1:0] sel_q, sel_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] shadow_q, shadow_d;
   logic [3:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic [7:0] frames_q, frames_d;

   // Next-state logic: dwell counting, channel capture and frame completion.
   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path
      // through this block leaves a value unassigned and no latch is inferred.
      state_d  = state_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      frames_d = frames_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SCAN;
               sel_d   = 2'd0;
               cnt_d   = 4'd0;
            end
         end

         SCAN: begin
            if (cnt_q != CNT_LAST) begin
               cnt_d = cnt_q + 4'd1;
            end else begin
               cnt_d = 4'd0;
               // Wraps 3 -> 0 at frame end, so the next frame starts on ch a.
               sel_d = sel_q + 2'd1;
               case (sel_q)
                  2'd0: shadow_d[0] = z;
                  2'd1: shadow_d[1] = z;
                  2'd2: shadow_d[2] = z;
                  default: begin
                     // Channel d completes the frame; continuous is only
                     // looked at here, so mid-frame changes are harmless.
                     data_d   = {z, shadow_q};
                     valid_d  = 1'b1;
                     frames_d = frames_q + 8'd1;
                     if (!continuous) begin
                        state_d = IDLE;
                     end
                  end
               endcase
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State registers; reset discards any partial frame immediately.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values computed above.
      if (reset) begin
         state_q  <= IDLE;
         sel_q    <= 2'd0;
         cnt_q    <= 4'd0;
         shadow_q <= 3'd0;
         data_q   <= 4'd0;
         valid_q  <= 1'b0;
         frames_q <= 8'd0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         frames_q <= frames_d;
      end
   end

   // The select lines come straight from the registered channel index, so
   // they are glitch-free and stable for the whole dwell window.
   assign s0     = sel_q[0];
   assign s1     = sel_q[1];
   assign busy   = (state_q == SCAN);
   assign data   = data_q;
   assign valid  = valid_q;
   assign frames = frames_q;

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 The block SHALL have one parameter: DWELL, default 4, clock cycles spent on each mux channel before its output is sampled (legal range 1..16).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, listed first in its ports.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request one scan frame; honoured only in IDLE.
REQ-006 continuous  input  1  when 1 at frame end, the next frame begins immediately.
REQ-007 z  input  1  output of the downstream 4:1 mux being scanned.
REQ-008 s0  output  1  mux select bit 0, registered.
REQ-009 s1  output  1  mux select bit 1, registered.
REQ-010 data  output  4  last completed frame: data[0]=ch a (s1s0=00), data[1]=ch b (01), data[2]=ch c (10), data[3]=ch d (11).
REQ-011 valid  output  1  one-cycle pulse; data updated this cycle.
REQ-012 busy  output  1  high while a frame is in progress.
REQ-013 frames  output  8  count of completed frames, wraps 255->0.

Function
REQ-014 The block SHALL implement a two-state FSM: IDLE and SCAN.
REQ-015 In IDLE, start=1 at a rising edge SHALL move the FSM to SCAN with channel index sel=0 and dwell counter cnt=0.
REQ-016 {s1,s0} SHALL equal sel at all times, registered, so the select is stable for the full dwell window.
REQ-017 In SCAN, cnt SHALL increment by 1 each cycle while cnt<DWELL-1.
REQ-018 At the edge where cnt==DWELL-1, the block SHALL capture z into shadow bit sel, clear cnt to 0, and advance sel by 1.
REQ-019 The capture for sel=3 SHALL load data with {z, shadow[2:0]}, pulse valid for exactly one cycle, increment frames, and wrap sel to 0.
REQ-020 At the sel=3 capture edge, continuous=1 SHALL keep the FSM in SCAN with no idle gap; continuous=0 SHALL return it to IDLE.
REQ-021 continuous SHALL be sampled only at the sel=3 capture edge; changes mid-frame SHALL have no effect until then.
REQ-022 Latency: valid SHALL assert on the 4*DWELL-th rising edge after the edge that accepted start.
REQ-023 busy SHALL be 1 exactly while the FSM is in SCAN and SHALL fall on the same edge that valid rises in a non-continuous frame.
REQ-024 start while busy SHALL be ignored, with no restart and no queued request.
REQ-025 With DWELL=1, each channel SHALL be sampled on consecutive cycles, giving a 4-cycle frame.
REQ-026 data and frames SHALL hold their values between valid pulses.
REQ-027 sel and cnt SHALL be 2 and 4 bits wide and SHALL never exceed 3 and DWELL-1 respectively.

Reset
REQ-028 Reset assertion SHALL immediately force: FSM=IDLE, sel=0, cnt=0, s0=0, s1=0, shadow=0, data=0, valid=0, busy=0, frames=0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame, with no valid pulse and no frames increment.
REQ-030 After reset deasserts, the block SHALL wait in IDLE for start.

Verification (DWELL=4 unless noted)
REQ-031 Reset then idle: reset pulse, start=0 for 20 cycles -> all outputs stay 0, {s1,s0}=00.
REQ-032 Single frame: mux inputs a=1,b=0,c=1,d=0, start pulse, continuous=0 -> select steps 00,01,10,11 for 4 cycles each; valid on the 16th edge with data=4'b0101, frames=1; busy low afterwards.
REQ-033 Continuous mode: continuous=1, a=b=c=d=1, then clear continuous during frame 3 -> valid every 16 cycles with data=4'b1111, exactly 3 valid pulses, frames=3, then IDLE.
REQ-034 Start while busy: start pulse at cycle 5 of a frame -> ignored; valid occurs only at cycle 16, with no second frame.
REQ-035 Reset mid-frame: reset at cycle 9 -> outputs at reset values, no valid pulse; a new start gives a full 16-cycle frame.
REQ-036 DWELL=1 and frames wrap: 256 continuous frames with only d=1 -> valid every 4 cycles, data=4'b1000, frames wraps 255->0.
